// File: rtl/note_key_mixer_pkg.sv
// rtl/note_key_mixer_pkg.sv - shared constants and helpers for the piano key/note mixer
package piano_pkg;

    localparam int CLK_HZ           = 50_000_000;
    localparam int DEFAULT_DEBOUNCE = CLK_HZ / 50;
    localparam int MAX_KEYS         = 16;

    function automatic logic [4:0] popcount(input logic [MAX_KEYS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Returns MAX_KEYS when no bit is set.
    function automatic logic [4:0] lowest_set_index(input logic [MAX_KEYS-1:0] v);
        logic [4:0] idx;
        idx = 5'(MAX_KEYS);
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/note_key_mixer_if.sv
// rtl/note_key_mixer_if.sv - key/note inputs and mixer outputs bundled for the note_key_mixer
interface note_key_mixer_if
    import piano_pkg::*;
#(
    parameter int NUM_KEYS = 8
);
    localparam int CW = count_width(NUM_KEYS);

    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] note_in;
    logic                mute;
    logic                mono;
    logic [NUM_KEYS-1:0] keys_pressed;
    logic [CW-1:0]       active_count;
    logic                speaker_out;

    modport master (
        output key_in, note_in, mute, mono,
        input  keys_pressed, active_count, speaker_out
    );

    modport slave (
        input  key_in, note_in, mute, mono,
        output keys_pressed, active_count, speaker_out
    );

endinterface

// File: rtl/note_key_mixer_debounce.sv
// rtl/note_key_mixer_debounce.sv - per-key 2-flop synchronizer and persistence-count debouncer
module key_debounce
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int CNTW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]      sync;
    logic [CNTW-1:0] cnt;

    // Any return to the stable level restarts the persistence count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNTW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/note_key_mixer.sv
// rtl/note_key_mixer.sv - debounced key gating of note waves mixed by a first-order sigma-delta
module note_key_mixer
    import piano_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic            clk,
    input  logic            reset,
    note_key_mixer_if.slave bus
);
    localparam int CW = count_width(NUM_KEYS);

    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] gated;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       level;
    logic [CW-1:0]       acc;
    logic                spk;

    logic [MAX_KEYS-1:0] keys_ext;
    logic [MAX_KEYS-1:0] gated_ext;
    logic [4:0]          prio;
    logic [CW:0]         sum;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.key_in[i]),
            .stable(keys[i])
        );
    end

    always_comb begin
        keys_ext                 = '0;
        keys_ext[NUM_KEYS-1:0]   = keys;
        gated_ext                = '0;
        gated_ext[NUM_KEYS-1:0]  = gated;
        prio                     = lowest_set_index(keys_ext);
        sum                      = {1'b0, acc} + {1'b0, level};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            gated   <= '0;
            level   <= '0;
        end else begin
            count_q <= CW'(popcount(keys_ext));
            gated   <= keys & bus.note_in;
            // Mono drives full scale so the output is the chosen note itself, not a duty fraction.
            if (bus.mono) begin
                if (prio == 5'(MAX_KEYS))
                    level <= '0;
                else
                    level <= gated_ext[prio[3:0]] ? CW'(NUM_KEYS) : '0;
            end else begin
                level <= CW'(popcount(gated_ext));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            spk <= 1'b0;
        end else if (bus.mute) begin
            acc <= '0;
            spk <= 1'b0;
        end else if (sum >= (CW+1)'(NUM_KEYS)) begin
            acc <= CW'(sum - (CW+1)'(NUM_KEYS));
            spk <= 1'b1;
        end else begin
            acc <= sum[CW-1:0];
            spk <= 1'b0;
        end
    end

    assign bus.keys_pressed = keys;
    assign bus.active_count = count_q;
    assign bus.speaker_out  = spk;

endmodule

// File: tb/tb_note_key_mixer.sv
// tb/tb_note_key_mixer.sv - directed self-checking bench for note_key_mixer
module tb_note_key_mixer;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   highs;
    logic [2:0]  hist;
    logic        n3;
    logic [7:0]  nv;

    note_key_mixer_if #(.NUM_KEYS(8)) bus ();

    note_key_mixer #(
        .NUM_KEYS       (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.key_in  = '0;
        bus.note_in = '0;
        bus.mute    = 1'b0;
        bus.mono    = 1'b0;
        cyc(3);
        check("reset_keys", 32'(bus.keys_pressed), 32'h0);
        check("reset_count", 32'(bus.active_count), 32'h0);
        check("reset_spk", 32'(bus.speaker_out), 32'h0);
        reset = 1'b0;
        cyc(1);

        // 1: clean press of key 2
        bus.key_in = 8'h04;
        cyc(5);
        check("t1_keys_c5", 32'(bus.keys_pressed), 32'h00);
        cyc(1);
        check("t1_keys_c6", 32'(bus.keys_pressed), 32'h04);
        check("t1_count_c6", 32'(bus.active_count), 32'h0);
        cyc(1);
        check("t1_count_c7", 32'(bus.active_count), 32'h1);
        check("t1_spk_silent", 32'(bus.speaker_out), 32'h0);
        bus.key_in = 8'h00;
        cyc(10);
        check("t1_release", 32'(bus.keys_pressed), 32'h00);

        // 2: 3-cycle bounce rejected, then held press accepted
        bus.key_in = 8'h01;
        cyc(3);
        bus.key_in = 8'h00;
        cyc(10);
        check("t2_bounce", 32'(bus.keys_pressed), 32'h00);
        bus.key_in = 8'h01;
        cyc(5);
        check("t2_hold_c5", 32'(bus.keys_pressed), 32'h00);
        cyc(1);
        check("t2_hold_c6", 32'(bus.keys_pressed), 32'h01);

        // 3: two notes held -> one high every four cycles
        bus.key_in = 8'h03;
        cyc(8);
        check("t3_keys", 32'(bus.keys_pressed), 32'h03);
        check("t3_count", 32'(bus.active_count), 32'h2);
        bus.note_in = 8'h03;
        highs = 0;
        for (int k = 1; k <= 18; k++) begin
            cyc(1);
            if (k >= 3) begin
                check($sformatf("t3_spk_c%0d", k), 32'(bus.speaker_out),
                      32'((k >= 6) && ((k - 6) % 4 == 0)));
                if (bus.speaker_out) highs++;
            end
        end
        check("t3_duty", 32'(highs), 32'd4);

        // 4: all notes full scale, then mute
        bus.key_in = 8'hFF;
        cyc(8);
        check("t4_keys", 32'(bus.keys_pressed), 32'hFF);
        check("t4_count", 32'(bus.active_count), 32'h8);
        bus.note_in = 8'hFF;
        cyc(2);
        for (int k = 3; k <= 10; k++) begin
            cyc(1);
            check($sformatf("t4_full_c%0d", k), 32'(bus.speaker_out), 32'h1);
        end
        bus.mute = 1'b1;
        cyc(1);
        check("t4_mute1", 32'(bus.speaker_out), 32'h0);
        cyc(1);
        check("t4_mute2", 32'(bus.speaker_out), 32'h0);
        bus.mute = 1'b0;
        cyc(1);
        check("t4_unmute", 32'(bus.speaker_out), 32'h1);

        // 5: mono follows the lowest pressed key's note, delayed 3 clk
        bus.mono   = 1'b1;
        bus.key_in = 8'h28;
        cyc(8);
        check("t5_keys", 32'(bus.keys_pressed), 32'h28);
        hist = 3'b111;
        for (int t = 0; t < 16; t++) begin
            check($sformatf("t5_mono_t%0d", t), 32'(bus.speaker_out), 32'(hist[2]));
            n3 = ((t >> 1) & 1) != 0;
            nv = 8'($urandom);
            nv[3] = n3;
            bus.note_in = nv;
            hist = {hist[1:0], n3};
            cyc(1);
        end

        // 6: asynchronous reset mid-tone, keys held through it
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_keys", 32'(bus.keys_pressed), 32'h00);
        check("t6_rst_count", 32'(bus.active_count), 32'h0);
        check("t6_rst_spk", 32'(bus.speaker_out), 32'h0);
        cyc(2);
        reset = 1'b0;
        cyc(5);
        check("t6_rekey_c5", 32'(bus.keys_pressed), 32'h00);
        cyc(1);
        check("t6_rekey_c6", 32'(bus.keys_pressed), 32'h28);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
